// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and registered status readback.
// Optional parity bit (even, CTRL.PAR_ODD inverts) is enabled by defining MMIO_UART_PARITY_EN.
module mmio_uart_tx #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BASE_ADDR    = 32'hA000_0000,
    parameter int              CLKS_PER_BIT = 868,
    parameter int              FIFO_DEPTH   = 16
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_write_en_i,
    input  logic [XLEN-1:0] mem_write_data_i,
    input  logic            mem_read_en_i,
    output logic [XLEN-1:0] mem_read_data_o,
    output logic            uart_tx_o,
    output logic            tx_busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0] OFF_CTRL = 4'h0, OFF_TXDATA = 4'h4, OFF_STATUS = 4'h8;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_state_next;
    logic            r_tx_en, r_ovf, r_busy;
    logic [XLEN-1:0] r_rdata, w_rd_val;
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr, w_level;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift, w_head;
    logic            w_hit, w_wr, w_empty, w_full, w_can_pop, w_pop, w_push_req, w_push;
    logic            w_baud_done, w_tx_bit;
    logic [3:0]      w_offset;
    logic            w_unused_wdata;
`ifdef MMIO_UART_PARITY_EN
    logic            r_par_odd, r_parity;
`endif

    assign w_hit       = (mem_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign w_offset    = mem_addr_i[3:0];
    assign w_wr        = mem_write_en_i && w_hit;
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (w_level == LVL_FULL);
    assign w_head      = r_fifo[r_rd_ptr[AW-1:0]];
    assign w_can_pop   = r_tx_en && !w_empty;
    assign w_push_req  = w_wr && (w_offset == OFF_TXDATA);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_unused_wdata = ^mem_write_data_i[XLEN-1:8];

    // NOTE: the FIFO storage has no reset; the pointers alone define validity, so clearing the array buys nothing.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= mem_write_data_i[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_tx_en  <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_rdata  <= '0;
`ifdef MMIO_UART_PARITY_EN
            r_par_odd <= 1'b0;
`endif
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            if (w_wr && w_offset == OFF_CTRL) begin
                r_tx_en <= mem_write_data_i[0];
`ifdef MMIO_UART_PARITY_EN
                r_par_odd <= mem_write_data_i[1];
`endif
            end
            if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            else if (w_wr && w_offset == OFF_STATUS && mem_write_data_i[3])
                r_ovf <= 1'b0;
            r_busy <= (r_state != S_IDLE) || w_can_pop;
            if (mem_read_en_i) r_rdata <= w_hit ? w_rd_val : '0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef MMIO_UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_baud <= (r_state == S_IDLE || w_baud_done) ? '0 : r_baud + CW'(1);
            if (w_pop) begin
                r_shift   <= w_head;
                r_bit_cnt <= '0;
`ifdef MMIO_UART_PARITY_EN
                r_parity  <= ^w_head;
`endif
            end else if (r_state == S_DATA && w_baud_done) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_can_pop) w_state_next = S_START;
            S_START: if (w_baud_done) w_state_next = S_DATA;
            S_DATA:
                if (w_baud_done && r_bit_cnt == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            S_PARITY: if (w_baud_done) w_state_next = S_STOP;
            S_STOP:  if (w_baud_done) w_state_next = w_can_pop ? S_START : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_tx_bit = 1'b1;
        w_pop    = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_can_pop;
            S_START: w_tx_bit = 1'b0;
            S_DATA:  w_tx_bit = r_shift[0];
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: w_tx_bit = r_parity ^ r_par_odd;
`endif
            S_STOP:  w_pop = w_baud_done && w_can_pop;
            default: w_tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_val = '0;
        case (w_offset)
            OFF_CTRL: begin
                w_rd_val[0] = r_tx_en;
`ifdef MMIO_UART_PARITY_EN
                w_rd_val[1] = r_par_odd;
`endif
            end
            OFF_STATUS: begin
                w_rd_val[0]        = w_full;
                w_rd_val[1]        = w_empty;
                w_rd_val[2]        = r_busy;
                w_rd_val[3]        = r_ovf;
                w_rd_val[8 +: AW+1] = w_level;
            end
            default: w_rd_val = '0;
        endcase
    end

    assign uart_tx_o       = w_tx_bit;
    assign tx_busy_o       = r_busy;
    assign mem_read_data_o = r_rdata;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;
    localparam logic [31:0] A_CTRL = 32'hA000_0000, A_TXD = 32'hA000_0004;
    localparam logic [31:0] A_STAT = 32'hA000_0008, A_RSV = 32'hA000_000C;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        we = 1'b0, re = 1'b0, tx, busy;
    int          checks = 0, errors = 0;
    logic        cap [0:1023];

    mmio_uart_tx #(.XLEN(32), .BASE_ADDR(32'hA000_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .resetn_i(resetn), .mem_addr_i(addr), .mem_write_en_i(we),
        .mem_write_data_i(wdata), .mem_read_en_i(re), .mem_read_data_o(rdata),
        .uart_tx_o(tx), .tx_busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); addr = a; wdata = d; we = 1'b1;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); addr = a; re = 1'b1;
        @(negedge clk); re = 1'b0; d = rdata;
    endtask

    // Waits (bounded) for the line to drop, then records n per-cycle samples from that point.
    task automatic capture(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            cap[0] = tx;
            for (int i = 1; i < n; i++) begin @(negedge clk); cap[i] = tx; end
        end
    endtask

    function automatic logic [63:0] exp_wave(input logic [7:0] b);
        logic [NB-1:0] fr;
        logic [63:0]   w;
        fr = '1; fr[0] = 1'b0; fr[8:1] = b;
`ifdef MMIO_UART_PARITY_EN
        fr[9] = ^b;
`endif
        w = '0;
        for (int c = 0; c < FL; c++) w[c] = fr[c / CPB];
        return w;
    endfunction

    function automatic logic [63:0] act_wave(input int f);
        logic [63:0] w;
        w = '0;
        for (int c = 0; c < FL; c++) w[c] = cap[f * FL + c];
        return w;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h expected 00000002", d); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_single_byte();
        bit ok;
        wr(A_TXD, 32'h48);
        wr(A_CTRL, 32'h1);
        capture(FL, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no start bit expected one"); end
        else begin
            checks++;
            if (act_wave(0) !== exp_wave(8'h48)) begin
                errors++; $display("FAIL single_frame: got %h expected %h", act_wave(0), exp_wave(8'h48));
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL single_idle: got busy=%b tx=%b expected busy=0 tx=1", busy, tx);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        @(negedge clk); addr = A_CTRL; wdata = 32'h1; we = 1'b1; re = 1'b1;
        @(negedge clk); we = 1'b0; re = 1'b0;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rw_old_value: got %h expected 0", rdata); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rw_new_value: got %h expected 1", d); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bit ok;
        int lows = 0;
        for (int i = 0; i < 5; i++) wr(A_TXD, {24'h0, b[i]});
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0409) begin errors++; $display("FAIL ovf_status: got %h expected 00000409", d); end
        wr(A_STAT, 32'h8);
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0401) begin errors++; $display("FAIL ovf_w1c: got %h expected 00000401", d); end
        wr(A_CTRL, 32'h1);
        capture(4 * FL, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got no start bit expected one"); end
        else for (int f = 0; f < 4; f++) begin
            checks++;
            if (act_wave(f) !== exp_wave(b[f])) begin
                errors++; $display("FAIL ovf_frame%0d: got %h expected %h", f, act_wave(f), exp_wave(b[f]));
            end
        end
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL ovf_dropped_byte: got %0d low cycles expected 0", lows); end
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL ovf_drained: got %h expected 00000002", d); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [7:0]  b [5] = '{8'hFF, 8'hA1, 8'h3C, 8'h96, 8'h7E};
        bit ok;
        for (int i = 0; i < 4; i++) wr(A_TXD, {24'h0, b[i]});
        @(negedge clk); addr = A_CTRL; wdata = 32'h1; we = 1'b1;
        @(negedge clk); addr = A_TXD; wdata = {24'h0, b[4]};
        @(negedge clk); we = 1'b0; addr = A_STAT; re = 1'b1;
        @(negedge clk); re = 1'b0; d = rdata;
        checks++; if (d !== 32'h0000_0405) begin errors++; $display("FAIL fullpp_status: got %h expected 00000405", d); end
        // First byte is 0xFF, so after its start bit the line stays high until the next frame.
        repeat (2 * CPB) @(negedge clk);
        capture(4 * FL, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fullpp_timeout: got no start bit expected one"); end
        else for (int f = 0; f < 4; f++) begin
            checks++;
            if (act_wave(f) !== exp_wave(b[f + 1])) begin
                errors++; $display("FAIL fullpp_frame%0d: got %h expected %h", f, act_wave(f), exp_wave(b[f + 1]));
            end
        end
        repeat (10) @(negedge clk);
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  b [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        bit ok;
        for (int i = 0; i < 4; i++) wr(A_TXD, {24'h0, b[i]});
        fork
            begin
                wr(A_CTRL, 32'h1);
                repeat (10) @(negedge clk);
                wr(A_TXD, {24'h0, b[4]});
            end
            capture(5 * FL, ok);
        join
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no start bit expected one"); end
        else for (int f = 0; f < 5; f++) begin
            checks++;
            if (act_wave(f) !== exp_wave(b[f])) begin
                errors++; $display("FAIL b2b_frame%0d: got %h expected %h", f, act_wave(f), exp_wave(b[f]));
            end
        end
        repeat (4) @(negedge clk);
        rd(A_STAT, d);
        checks++; if ((d & 32'h0000_FF03) !== 32'h0000_0002) begin
            errors++; $display("FAIL b2b_empty: got %h expected level 0 and empty", d);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_txen_clear();
        logic [31:0] d;
        bit ok;
        int lows = 0;
        wr(A_TXD, 32'h5A); wr(A_TXD, 32'hC3); wr(A_TXD, 32'h0F);
        fork
            begin
                wr(A_CTRL, 32'h1);
                repeat (8) @(negedge clk);
                wr(A_CTRL, 32'h0);
            end
            capture(FL, ok);
        join
        checks++; if (!ok) begin errors++; $display("FAIL txen_timeout: got no start bit expected one"); end
        else begin
            checks++;
            if (act_wave(0) !== exp_wave(8'h5A)) begin
                errors++; $display("FAIL txen_frame: got %h expected %h", act_wave(0), exp_wave(8'h5A));
            end
        end
        for (int i = 0; i < 3 * FL; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL txen_line_idle: got %0d low cycles expected 0", lows); end
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL txen_status: got %h expected 00000200", d); end
        rd(A_RSV, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
        rd(A_TXD, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
        rd(A_CTRL, d);
        rd(32'hB000_0008, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL miss_read: got %h expected 0", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        bit seen = 1'b0;
        int lows = 0;
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, d);
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); if (tx === 1'b0) seen = 1'b1; end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_timeout: got no start bit expected one"); end
        repeat (6) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata); end
        @(negedge clk); resetn = 1'b1;
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000002", d); end
        for (int i = 0; i < 2 * FL; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL rst_mid_idle: got %0d low cycles expected 0", lows); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_rw_same_cycle();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_txen_clear();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
